// File: rtl/bp_defs.sv
// Shared branch-predictor definitions: counter encodings and
// default geometry used by the PHT, BTB and GHR blocks.
package bp_defs;

    localparam int CNT_W = 2;

    typedef enum logic [CNT_W-1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    localparam int              DEF_IDX_W    = 6;
    localparam logic [CNT_W-1:0] DEF_INIT_CNT = 2'b01;

endpackage

// File: rtl/pht_cnt_next.sv
// Saturating 2-bit counter next value: increment on taken,
// decrement on not taken, clamped at ST and SNT.
module pht_cnt_next
    import bp_defs::*;
(
    input  logic [CNT_W-1:0] cnt,
    input  logic             taken,
    output logic [CNT_W-1:0] nxt
);

    // Step toward the outcome, holding at either end.
    always_comb begin
        nxt = cnt;
        if (taken) begin
            if (cnt != ST) nxt = cnt + 2'd1;
        end else begin
            if (cnt != SNT) nxt = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/pht_counter_table.sv
// Pattern history table: flop array of saturating counters with a
// 1-cycle predict port and a 2-stage update pipeline with bypass.
module pht_counter_table
    import bp_defs::*;
#(
    parameter int               IDX_W    = DEF_IDX_W,
    parameter logic [CNT_W-1:0] INIT_CNT = DEF_INIT_CNT
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             PredValid,
    input  logic [IDX_W-1:0] PredIndex,
    output logic             PredRspValid,
    output logic [CNT_W-1:0] PredCounter,
    output logic             PredTaken,
    input  logic             UpdValid,
    input  logic [IDX_W-1:0] UpdIndex,
    input  logic             UpdTaken,
    output logic             UpdPending
);

    localparam int DEPTH = 1 << IDX_W;

    logic [CNT_W-1:0] mem [DEPTH];

    logic             u1_valid;
    logic             u1_taken;
    logic [IDX_W-1:0] u1_idx;

    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] byp_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] lookup_cnt;
    logic             hit;

    assign rd_cnt = mem[PredIndex];
    assign hit    = u1_valid && (u1_idx == PredIndex);

    // The write lands on the same edge the lookup samples, so a hit
    // on the pending entry must see the post-update value.
    assign lookup_cnt = hit ? byp_cnt : rd_cnt;

    pht_cnt_next u_nv_wr (
        .cnt   (mem[u1_idx]),
        .taken (u1_taken),
        .nxt   (wr_cnt)
    );

    pht_cnt_next u_nv_byp (
        .cnt   (rd_cnt),
        .taken (u1_taken),
        .nxt   (byp_cnt)
    );

    // U1: capture the incoming update request.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            u1_valid <= 1'b0;
            u1_idx   <= '0;
            u1_taken <= 1'b0;
        end else begin
            u1_valid <= UpdValid;
            u1_idx   <= UpdIndex;
            u1_taken <= UpdTaken;
        end
    end

    // U2: read-modify-write of the counter array.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT_CNT;
            end
        end else if (u1_valid) begin
            mem[u1_idx] <= wr_cnt;
        end
    end

    // Predict response register; counter holds between lookups.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            PredRspValid <= 1'b0;
            PredCounter  <= INIT_CNT;
        end else begin
            PredRspValid <= PredValid;
            if (PredValid) PredCounter <= lookup_cnt;
        end
    end

    assign PredTaken  = PredCounter[1];
    assign UpdPending = u1_valid;

endmodule

// File: tb/tb_pht_counter_table.sv
// Directed and randomized checks of the PHT predict/update ports
// against hand-computed values and a visibility-rule model.
module tb_pht_counter_table;

    logic       Clk;
    logic       Rst_n;
    logic       PredValid;
    logic [5:0] PredIndex;
    logic       PredRspValid;
    logic [1:0] PredCounter;
    logic       PredTaken;
    logic       UpdValid;
    logic [5:0] UpdIndex;
    logic       UpdTaken;
    logic       UpdPending;

    int n_chk;
    int n_pass;

    int m_arr [64];
    int m_cnt;
    int m_rsp;
    int m_pend;

    pht_counter_table #(
        .IDX_W    (6),
        .INIT_CNT (2'b01)
    ) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .PredValid    (PredValid),
        .PredIndex    (PredIndex),
        .PredRspValid (PredRspValid),
        .PredCounter  (PredCounter),
        .PredTaken    (PredTaken),
        .UpdValid     (UpdValid),
        .UpdIndex     (UpdIndex),
        .UpdTaken     (UpdTaken),
        .UpdPending   (UpdPending)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int c, input int t);
        int r;
        r = t ? c + 1 : c - 1;
        if (r > 3) r = 3;
        if (r < 0) r = 0;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_arr[i] = 1;
        m_cnt  = 1;
        m_rsp  = 0;
        m_pend = 0;
    endtask

    // Model: an update is visible to any lookup from the next edge on.
    task automatic cyc(input logic pv, input logic [5:0] pi,
                       input logic uv, input logic [5:0] ui,
                       input logic ut);
        PredValid = pv;
        PredIndex = pi;
        UpdValid  = uv;
        UpdIndex  = ui;
        UpdTaken  = ut;
        @(posedge Clk);
        #1;
        if (pv) m_cnt = m_arr[pi];
        m_rsp = int'(pv);
        if (uv) m_arr[ui] = sat(m_arr[ui], int'(ut));
        m_pend = int'(uv);
    endtask

    task automatic idle();
        cyc(1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic upd(input logic [5:0] ui, input logic ut);
        cyc(1'b0, 6'd0, 1'b1, ui, ut);
    endtask

    task automatic look(input logic [5:0] pi);
        cyc(1'b1, pi, 1'b0, 6'd0, 1'b0);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        model_reset();
        Rst_n     = 1'b0;
        PredValid = 1'b0;
        PredIndex = '0;
        UpdValid  = 1'b0;
        UpdIndex  = '0;
        UpdTaken  = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_rsp", int'(PredRspValid), 0);
        chk("rst_cnt", int'(PredCounter), 1);
        chk("rst_tkn", int'(PredTaken), 0);
        chk("rst_pend", int'(UpdPending), 0);
        Rst_n = 1'b1;

        // traffic, then asynchronous reset mid-operation
        upd(6'd0, 1'b1);
        cyc(1'b1, 6'd0, 1'b1, 6'd17, 1'b1);
        chk("pre_rst_cnt", int'(PredCounter), 2);
        chk("pre_rst_pend", int'(UpdPending), 1);
        cyc(1'b1, 6'd63, 1'b1, 6'd63, 1'b1);
        #2;
        Rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_rsp", int'(PredRspValid), 0);
        chk("arst_cnt", int'(PredCounter), 1);
        chk("arst_pend", int'(UpdPending), 0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        idle();

        look(6'd0);
        chk("init0_rsp", int'(PredRspValid), 1);
        chk("init0_cnt", int'(PredCounter), 1);
        chk("init0_tkn", int'(PredTaken), 0);
        look(6'd17);
        chk("init17_rsp", int'(PredRspValid), 1);
        chk("init17_cnt", int'(PredCounter), 1);
        look(6'd63);
        chk("init63_rsp", int'(PredRspValid), 1);
        chk("init63_cnt", int'(PredCounter), 1);
        chk("init63_tkn", int'(PredTaken), 0);
        idle();
        chk("idle_rsp", int'(PredRspValid), 0);
        chk("idle_hold", int'(PredCounter), 1);

        // saturation up
        repeat (4) upd(6'd5, 1'b1);
        chk("up_pend", int'(UpdPending), 1);
        look(6'd5);
        chk("up_cnt", int'(PredCounter), 3);
        chk("up_tkn", int'(PredTaken), 1);
        chk("up_pend0", int'(UpdPending), 0);
        upd(6'd5, 1'b1);
        look(6'd5);
        chk("up5_cnt", int'(PredCounter), 3);

        // saturation down
        repeat (4) upd(6'd5, 1'b0);
        look(6'd5);
        chk("dn_cnt", int'(PredCounter), 0);
        repeat (2) upd(6'd5, 1'b0);
        look(6'd5);
        chk("dn_more_cnt", int'(PredCounter), 0);
        chk("dn_tkn", int'(PredTaken), 0);

        // back-to-back RMW on one index
        upd(6'd9, 1'b1);
        upd(6'd9, 1'b1);
        upd(6'd9, 1'b0);
        idle();
        look(6'd9);
        chk("b2b_cnt", int'(PredCounter), 2);
        chk("b2b_tkn", int'(PredTaken), 1);

        // bypass: same-cycle not visible, next cycle visible
        cyc(1'b1, 6'd3, 1'b1, 6'd3, 1'b1);
        chk("byp_same", int'(PredCounter), 1);
        look(6'd3);
        chk("byp_next", int'(PredCounter), 2);

        // mixed random traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic       pv;
            logic       uv;
            logic       ut;
            logic [5:0] pi;
            logic [5:0] ui;
            pv = 1'($urandom_range(0, 1));
            uv = 1'($urandom_range(0, 1));
            ut = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                pi = 6'($urandom_range(0, 63));
                ui = 6'($urandom_range(0, 63));
            end else begin
                pi = 6'($urandom_range(0, 3));
                ui = 6'($urandom_range(0, 3));
            end
            cyc(pv, pi, uv, ui, ut);
            chk("rnd_rsp", int'(PredRspValid), m_rsp);
            chk("rnd_cnt", int'(PredCounter), m_cnt);
            chk("rnd_tkn", int'(PredTaken), m_cnt / 2);
            chk("rnd_pend", int'(UpdPending), m_pend);
        end

        // final sweep of every entry against the model
        idle();
        for (int i = 0; i < 64; i++) begin
            look(6'(i));
            chk("sweep_cnt", int'(PredCounter), m_arr[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
